// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy flags, programmable almost-full/almost-empty and sticky errors.
// Latency: FWFT=0 -> rd_data valid one cycle after the read edge; FWFT=1 -> head word shown whenever non-empty.
// Backpressure: writes while full and reads while empty are dropped and latch overflow/underflow.
//
// Ports:
//   clk, rst            sole clock, synchronous active-high reset
//   wr_en, wr_data      push request and word (accepted only when not full)
//   rd_en               pop request (accepted only when not empty)
//   err_clr             clears the sticky overflow/underflow flags
//   rd_data             read word (registered or fall-through depending on FWFT)
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow, underflow sticky error flags
//
// Parameter legality: 2 <= ADDR_WIDTH <= 10, 1 <= AE_THRESH < AF_THRESH <= 2**ADDR_WIDTH-1.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = (2**ADDR_WIDTH) - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int FIFO_DEPTH = 2**ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_AE   = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come straight from the count register, so they describe the state
    // left by the previous edge; acceptance below therefore uses pre-edge flags.
    assign count        = count_q;
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Storage is not reset: pointers and count are, so stale words are unreachable.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !err_clr) || (wr_en && full);
            underflow <= (underflow && !err_clr) || (rd_en && empty);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown combinationally; a word written into an empty
            // FIFO becomes visible as soon as count leaves zero.
            assign rd_data = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_q;

            // Rejected reads return zero rather than a stale word.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= rd_acc ? mem[rd_ptr] : '0;
                end
            end

            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: a registered-read and a fall-through
// instance share all inputs and are compared against a queue-based model.
// Runs directed scenarios followed by a randomized stress phase.
module tb_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;

    logic [DW-1:0] rd_data0, rd_data1;
    logic          full0, empty0, afull0, aempty0, ovf0, unf0;
    logic          full1, empty1, afull1, aempty1, ovf1, unf1;
    logic [AW:0]   count0, count1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [DW-1:0] m_rd0 = '0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
                      .AF_THRESH(AF), .AE_THRESH(AE)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .err_clr(err_clr), .rd_data(rd_data0), .full(full0), .empty(empty0),
        .almost_full(afull0), .almost_empty(aempty0), .count(count0),
        .overflow(ovf0), .underflow(unf0));

    sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
                      .AF_THRESH(AF), .AE_THRESH(AE)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .err_clr(err_clr), .rd_data(rd_data1), .full(full1), .empty(empty1),
        .almost_full(afull1), .almost_empty(aempty1), .count(count1),
        .overflow(ovf1), .underflow(unf1));

    function automatic int m_cnt();
        return q.size();
    endfunction

    function automatic logic [DW-1:0] m_head();
        return (q.size() == 0) ? '0 : q[0];
    endfunction

    // Drive one cycle, advance the model with pre-edge occupancy, sample #1 after the edge.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic c, input logic rs);
        logic was_full, was_empty, wacc, racc;
        wr_en = w; wr_data = d; rd_en = r; err_clr = c; rst = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rd0 = '0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            wacc = w && !was_full;
            racc = r && !was_empty;
            if (r) m_rd0 = racc ? q[0] : '0;
            if (racc) void'(q.pop_front());
            if (wacc) q.push_back(d);
            m_ovf = (m_ovf && !c) || (w && was_full);
            m_unf = (m_unf && !c) || (r && was_empty);
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 0, 0, 1);
        checks++; if (count0 !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count0); end
        checks++; if ({full0, empty0, afull0, aempty0} !== 4'b0101) begin errors++; $display("FAIL reset_flags got %b exp 0101", {full0, empty0, afull0, aempty0}); end
        checks++; if ({ovf0, unf0, ovf1, unf1} !== 4'b0000) begin errors++; $display("FAIL reset_err got %b exp 0000", {ovf0, unf0, ovf1, unf1}); end
        checks++; if (rd_data0 !== 8'h00 || rd_data1 !== 8'h00) begin errors++; $display("FAIL reset_rd got %h/%h exp 00/00", rd_data0, rd_data1); end
        checks++; if (count1 !== 5'd0 || empty1 !== 1'b1) begin errors++; $display("FAIL reset_fwft got cnt %0d empty %b exp 0 1", count1, empty1); end
    endtask

    task automatic test_order();
        for (int i = 0; i < 10; i++) cyc(1, 8'(i), 0, 0, 0);
        checks++; if (count0 !== 5'd10) begin errors++; $display("FAIL order_fill_count got %0d exp 10", count0); end
        for (int i = 0; i < 10; i++) begin
            cyc(0, '0, 1, 0, 0);
            checks++; if (rd_data0 !== 8'(i)) begin errors++; $display("FAIL order_rd%0d got %h exp %h", i, rd_data0, 8'(i)); end
        end
        checks++; if (count0 !== 5'd0 || empty0 !== 1'b1) begin errors++; $display("FAIL order_drain got cnt %0d empty %b exp 0 1", count0, empty0); end
        // rd_data holds with rd_en low
        cyc(0, '0, 0, 0, 0);
        checks++; if (rd_data0 !== 8'd9) begin errors++; $display("FAIL order_hold got %h exp 09", rd_data0); end
    endtask

    task automatic test_full_overflow();
        logic [DW-1:0] exp;
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'($urandom_range(0, 254)), 0, 0, 0);
        checks++; if (full0 !== 1'b1 || count0 !== 5'd16) begin errors++; $display("FAIL full_state got full %b cnt %0d exp 1 16", full0, count0); end
        cyc(1, 8'hFF, 0, 0, 0);
        checks++; if (ovf0 !== 1'b1 || ovf1 !== 1'b1) begin errors++; $display("FAIL overflow_set got %b/%b exp 1", ovf0, ovf1); end
        checks++; if (count0 !== 5'd16) begin errors++; $display("FAIL overflow_count got %0d exp 16", count0); end
        for (int i = 0; i < DEPTH; i++) begin
            exp = q[0];
            cyc(0, '0, 1, 0, 0);
            checks++; if (rd_data0 !== exp || rd_data0 === 8'hFF) begin errors++; $display("FAIL full_rd%0d got %h exp %h", i, rd_data0, exp); end
        end
        cyc(0, '0, 0, 1, 0);
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL overflow_clr got %b exp 0", ovf0); end
    endtask

    task automatic test_underflow();
        cyc(0, '0, 1, 0, 0);
        checks++; if (unf0 !== 1'b1 || unf1 !== 1'b1) begin errors++; $display("FAIL underflow_set got %b/%b exp 1", unf0, unf1); end
        checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL underflow_rd got %h exp 00", rd_data0); end
        cyc(0, '0, 0, 1, 0);
        checks++; if (unf0 !== 1'b0) begin errors++; $display("FAIL underflow_clr got %b exp 0", unf0); end
        cyc(0, '0, 1, 1, 0);
        checks++; if (unf0 !== 1'b1) begin errors++; $display("FAIL underflow_set_wins got %b exp 1", unf0); end
        // read on empty with simultaneous write is rejected
        cyc(1, 8'h3C, 1, 1, 0);
        checks++; if (count0 !== 5'd1 || rd_data0 !== 8'h00) begin errors++; $display("FAIL empty_rw got cnt %0d rd %h exp 1 00", count0, rd_data0); end
        cyc(0, '0, 1, 1, 0);
        checks++; if (rd_data0 !== 8'h3C || unf0 !== 1'b0) begin errors++; $display("FAIL empty_rw_pop got rd %h unf %b exp 3c 0", rd_data0, unf0); end
    endtask

    task automatic test_thresholds();
        logic [DW-1:0] exp;
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1, 8'(i), 0, 0, 0);
            checks++; if (afull0 !== (i >= AF) || aempty0 !== (i <= AE)) begin errors++; $display("FAIL thresh_cnt%0d got af %b ae %b exp %b %b", i, afull0, aempty0, i >= AF, i <= AE); end
        end
        cyc(1, 8'hFF, 1, 1, 0);
        checks++; if (count0 !== 5'd15 || full0 !== 1'b0) begin errors++; $display("FAIL full_rw got cnt %0d full %b exp 15 0", count0, full0); end
        checks++; if (rd_data0 !== 8'd1 || ovf0 !== 1'b1) begin errors++; $display("FAIL full_rw_rd got rd %h ovf %b exp 01 1", rd_data0, ovf0); end
        for (int i = 2; i <= DEPTH; i++) begin
            exp = 8'(i);
            cyc(0, '0, 1, 0, 0);
            checks++; if (rd_data0 !== exp) begin errors++; $display("FAIL full_rw_drain%0d got %h exp %h", i, rd_data0, exp); end
        end
        cyc(0, '0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp;
        for (int i = 0; i < 5; i++) cyc(1, 8'(100 + i), 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            exp = 8'(100 + i);
            cyc(1, 8'(105 + i), 1, 0, 0);
            checks++; if (rd_data0 !== exp || count0 !== 5'd5) begin errors++; $display("FAIL stream%0d got rd %h cnt %0d exp %h 5", i, rd_data0, count0, exp); end
        end
        for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0, 0);
        checks++; if (rd_data0 !== 8'd144 || empty0 !== 1'b1) begin errors++; $display("FAIL stream_tail got rd %h empty %b exp 90 1", rd_data0, empty0); end
    endtask

    task automatic test_fwft();
        cyc(0, '0, 0, 0, 1);
        cyc(1, 8'hA5, 0, 0, 0);
        checks++; if (rd_data1 !== 8'hA5 || empty1 !== 1'b0) begin errors++; $display("FAIL fwft_first got rd %h empty %b exp a5 0", rd_data1, empty1); end
        for (int i = 0; i < 5; i++) cyc(1, 8'(i + 1), 0, 0, 0);
        checks++; if (rd_data1 !== 8'hA5 || count1 !== 5'd6) begin errors++; $display("FAIL fwft_head got rd %h cnt %0d exp a5 6", rd_data1, count1); end
        cyc(0, '0, 1, 0, 0);
        checks++; if (rd_data1 !== 8'h01) begin errors++; $display("FAIL fwft_pop got %h exp 01", rd_data1); end
        cyc(1, 8'hEE, 1, 0, 1);
        checks++; if (count1 !== 5'd0 || empty1 !== 1'b1 || rd_data1 !== 8'h00) begin errors++; $display("FAIL fwft_rst got cnt %0d empty %b rd %h exp 0 1 00", count1, empty1, rd_data1); end
        cyc(1, 8'h5A, 0, 0, 0);
        cyc(0, '0, 1, 0, 0);
        checks++; if (rd_data0 !== 8'h5A || empty1 !== 1'b1) begin errors++; $display("FAIL rst_discard got rd %h empty %b exp 5a 1", rd_data0, empty1); end
    endtask

    task automatic test_random();
        logic w, r, c, rs;
        for (int i = 0; i < 2000; i++) begin
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 45 + ((i / 250) % 2) * 20);
            c  = ($urandom_range(0, 99) < 5);
            rs = ($urandom_range(0, 999) < 3);
            cyc(w, 8'($urandom), r, c, rs);
            checks++; if (count0 !== 5'(m_cnt()) || count1 !== 5'(m_cnt())) begin errors++; $display("FAIL rnd_count@%0d got %0d/%0d exp %0d", i, count0, count1, m_cnt()); end
            checks++; if ({full0, empty0, afull0, aempty0} !== {m_cnt() == DEPTH, m_cnt() == 0, m_cnt() >= AF, m_cnt() <= AE}) begin errors++; $display("FAIL rnd_flags@%0d got %b cnt %0d", i, {full0, empty0, afull0, aempty0}, m_cnt()); end
            checks++; if ({ovf0, unf0, ovf1, unf1} !== {m_ovf, m_unf, m_ovf, m_unf}) begin errors++; $display("FAIL rnd_err@%0d got %b exp %b%b", i, {ovf0, unf0, ovf1, unf1}, m_ovf, m_unf); end
            checks++; if (rd_data0 !== m_rd0) begin errors++; $display("FAIL rnd_rd0@%0d got %h exp %h", i, rd_data0, m_rd0); end
            checks++; if (rd_data1 !== m_head()) begin errors++; $display("FAIL rnd_rd1@%0d got %h exp %h", i, rd_data1, m_head()); end
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full_overflow();
        test_underflow();
        test_thresholds();
        test_back_to_back();
        test_fwft();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
